// File: rtl/obi_dual_port_arbiter.sv
// Two-requester OBI arbiter: round-robin on ties, address phase held
// stable until grant, in-order response routing via an ID FIFO.
module obi_dual_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [1:0]                    req_i,
    output logic [1:0]                    gnt_o,
    input  logic [2*ADDR_WIDTH-1:0]       addr_i,
    input  logic [1:0]                    we_i,
    input  logic [2*(DATA_WIDTH/8)-1:0]   be_i,
    input  logic [2*DATA_WIDTH-1:0]       wdata_i,
    output logic [1:0]                    rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic                          mem_we_o,
    output logic [DATA_WIDTH/8-1:0]       mem_be_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                          err_o
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_sel;
    logic                       w_sel;
    logic                       r_last_gnt;
    logic                       r_err;
    logic [CNT_WIDTH-1:0]       r_count;
    logic [PTR_WIDTH-1:0]       r_wptr;
    logic [PTR_WIDTH-1:0]       r_rptr;
    logic [MAX_OUTSTANDING-1:0] r_id_q;

    logic w_space;
    logic w_mem_req;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_unexp;
    logic w_fwd;
    logic w_head;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // A response in this cycle frees a slot, so it also counts as space.
    assign w_space = (r_count < CNT_MAX) || mem_rvalid_i;
    assign w_pop   = mem_rvalid_i && (r_count != '0);
    assign w_unexp = mem_rvalid_i && (r_count == '0);
    assign w_head  = r_id_q[r_rptr];

    // Next-state and address-phase selection.
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = r_sel;
        w_mem_req   = 1'b0;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_space && (req_i != 2'b00)) begin
                    w_sel     = (req_i == 2'b11) ? ~r_last_gnt : req_i[1];
                    w_mem_req = 1'b1;
                    if (mem_gnt_i) begin
                        w_push = 1'b1;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                // Slot already reserved on entry; only the held request matters.
                w_mem_req = req_i[r_sel];
                if (!req_i[r_sel]) begin
                    w_drop      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (mem_gnt_i) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output drive; everything reads zero while reset is asserted.
    assign w_fwd       = rst_ni && w_mem_req;
    assign mem_req_o   = w_fwd;
    assign mem_addr_o  = !w_fwd ? '0 : (w_sel ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0]);
    assign mem_we_o    = w_fwd && (w_sel ? we_i[1] : we_i[0]);
    assign mem_be_o    = !w_fwd ? '0 : (w_sel ? be_i[2*BE_WIDTH-1:BE_WIDTH] : be_i[BE_WIDTH-1:0]);
    assign mem_wdata_o = !w_fwd ? '0 : (w_sel ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0]);
    assign gnt_o       = !(rst_ni && w_push) ? 2'b00 : (w_sel ? 2'b10 : 2'b01);
    assign rvalid_o    = !(rst_ni && w_pop) ? 2'b00 : (w_head ? 2'b10 : 2'b01);
    assign rdata_o     = rst_ni ? mem_rdata_i : '0;
    assign err_o       = r_err;

    // FSM state, selection and arbitration history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel;
            if (w_push) begin
                r_last_gnt <= w_sel;
            end
        end
    end

    // Outstanding-ID FIFO and occupancy counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_q  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_id_q[r_wptr] <= w_sel;
                r_wptr         <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_drop || w_unexp) begin
            r_err <= 1'b1;
        end
    end

endmodule
